// File: rtl/pipe_skid_reg.sv
// Two-entry skid-buffered pipeline register with registered in_ready and valid/ready handshakes.
// Optional synchronous flush port enabled by defining PIPE_SKID_FLUSH_EN.
module pipe_skid_reg #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
`ifdef PIPE_SKID_FLUSH_EN
  input  logic             flush,
`endif
  output logic [1:0]       count
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             flush_w;
  logic             in_fire;
  logic             out_fire;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_w) begin
      // Flush wins over everything; payload registers keep stale contents.
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d = StOne;
            main_d  = in_data;
          end
        end
        StOne: begin
          if (in_fire && !out_fire) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_fire) begin
            state_d = StOne;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Handshake outputs decode the state register only, so out_ready never reaches in_ready.
  always_comb begin
    out_valid = (state_q != StEmpty);
    in_ready  = (state_q != StFull);
    count     = state_q;
    out_data  = main_q;
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomized self-checking bench for pipe_skid_reg.
// Flush steps are compiled only when PIPE_SKID_FLUSH_EN is defined.
module tb_pipe_skid_reg;

  localparam int unsigned W = 16;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   count;
`ifdef PIPE_SKID_FLUSH_EN
  logic         flush;
`endif

  int nchk = 0;
  int nerr = 0;

  pipe_skid_reg #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
`ifdef PIPE_SKID_FLUSH_EN
    .flush    (flush),
`endif
    .count    (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic ov, input logic ir, input logic [1:0] c,
                         input logic [W-1:0] d);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(ir));
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".out_data"}, 32'(out_data), 32'(d));
  endtask

  logic [W-1:0] q[$];
  logic         iv;
  logic [W-1:0] idat;
  logic         ordy;
  logic         ir_snap;
  logic         mfire_in;
  logic         mfire_out;
  logic [W-1:0] seq;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    flush     = 1'b0;
`endif
    #1;
    chk_all("reset", 1'b0, 1'b1, 2'd0, 16'h0000);
    #21 rst_n = 1'b1;
    cyc();
    chk_all("post_reset", 1'b0, 1'b1, 2'd0, 16'h0000);

    // Streaming at one word per cycle.
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      cyc();
      chk_all($sformatf("stream%0d", i), 1'b1, 1'b1, 2'd1, 16'(i));
    end
    in_valid = 1'b0;
    cyc();
    chk_all("stream_drained", 1'b0, 1'b1, 2'd0, 16'h0008);

    // Fill then drain.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h00A1;
    cyc();
    chk_all("fill1", 1'b1, 1'b1, 2'd1, 16'h00A1);
    in_data = 16'h00B2;
    cyc();
    chk_all("fill2", 1'b1, 1'b0, 2'd2, 16'h00A1);
    in_valid = 1'b0;
    cyc();
    chk_all("full_hold", 1'b1, 1'b0, 2'd2, 16'h00A1);
    out_ready = 1'b1;
    cyc();
    chk_all("drain1", 1'b1, 1'b1, 2'd1, 16'h00B2);
    cyc();
    chk_all("drain2", 1'b0, 1'b1, 2'd0, 16'h00B2);

    // Simultaneous in_fire and out_fire while holding one word.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0010;
    cyc();
    chk_all("sim_head", 1'b1, 1'b1, 2'd1, 16'h0010);
    in_data   = 16'h0020;
    out_ready = 1'b1;
    cyc();
    chk_all("sim_replace", 1'b1, 1'b1, 2'd1, 16'h0020);
    in_valid = 1'b0;
    cyc();
    chk_all("sim_drain", 1'b0, 1'b1, 2'd0, 16'h0020);

`ifdef PIPE_SKID_FLUSH_EN
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0033;
    cyc();
    in_data = 16'h0044;
    cyc();
    chk_all("flush_full", 1'b1, 1'b0, 2'd2, 16'h0033);
    in_data = 16'h0055;
    flush   = 1'b1;
    cyc();
    chk_all("flush_empty", 1'b0, 1'b1, 2'd0, 16'h0033);
    flush    = 1'b0;
    in_valid = 1'b0;
    cyc();
    chk_all("flush_idle", 1'b0, 1'b1, 2'd0, 16'h0033);
    in_valid  = 1'b1;
    in_data   = 16'h0066;
    out_ready = 1'b1;
    cyc();
    chk_all("flush_next", 1'b1, 1'b1, 2'd1, 16'h0066);
    in_valid = 1'b0;
    cyc();
    chk_all("flush_drain", 1'b0, 1'b1, 2'd0, 16'h0066);
`endif

    // Asynchronous reset from FULL, applied away from a clock edge.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0077;
    cyc();
    in_data = 16'h0088;
    cyc();
    in_valid = 1'b0;
    chk_all("pre_rst_full", 1'b1, 1'b0, 2'd2, 16'h0077);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 1'b0, 1'b1, 2'd0, 16'h0000);
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk_all("rst_release", 1'b0, 1'b1, 2'd0, 16'h0000);

    // Random valid/ready traffic against a queue model.
    iv   = 1'b0;
    idat = '0;
    seq  = 16'h1000;
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      chk("rnd.in_ready", 32'(in_ready), 32'(q.size() < 2));
      chk("rnd.out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("rnd.count", 32'(count), 32'(q.size()));
      if (q.size() > 0) chk("rnd.out_data", 32'(out_data), 32'(q[0]));
      ir_snap = in_ready;
      if (!iv || $urandom_range(3) == 0) begin
        iv = ($urandom_range(3) != 0);
        if (iv) begin
          seq  = seq + 16'd1;
          idat = seq;
        end
      end
      ordy      = ($urandom_range(2) != 0);
      in_valid  = iv;
      in_data   = idat;
      out_ready = ordy;
      #1;
      chk("rnd.in_ready_stable", 32'(in_ready), 32'(ir_snap));
      mfire_in  = iv && (q.size() < 2);
      mfire_out = ordy && (q.size() > 0);
      if (mfire_out) void'(q.pop_front());
      if (mfire_in) begin
        q.push_back(idat);
        iv = 1'b0;
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
